// File: rtl/spi_initiator.sv
// SPI mode-0 initiator: one width-bit word per accepted start, MSB first, each sclk level held halfperiod clocks.
// Latency: cs falls 1 cycle after start; done pulses (2*width+1)*halfperiod+1 cycles after start; start is ignored while busy.
module spi_initiator #(
    parameter int width        = 8,
    parameter int halfperiod   = 5,
    parameter int counterwidth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [width-1:0] txdata,
    input  logic             miso,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] rxdata,
    output logic             cs,
    output logic             sclk,
    output logic             mosi
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    localparam int BW = $clog2(width + 1);
    localparam logic [counterwidth-1:0] LAST_PHASE = counterwidth'(halfperiod - 1);
    localparam logic [BW-1:0]           LAST_BIT   = BW'(width - 1);

    state_t                  state;
    logic [counterwidth-1:0] phase;
    logic [BW-1:0]           bits;
    logic [width-1:0]        tx;
    logic [width-1:0]        rx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            phase <= '0;
            bits  <= '0;
            tx    <= '0;
            rx    <= '0;
            cs    <= 1'b1;
            sclk  <= 1'b0;
            mosi  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            // An aborted transfer keeps the last completed word; only an idle reset clears it.
            if (state == IDLE)
                rxdata <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    tx    <= txdata;
                    mosi  <= txdata[width-1];
                    cs    <= 1'b0;
                    busy  <= 1'b1;
                    phase <= '0;
                    bits  <= '0;
                    state <= SETUP;
                end
            end else if (phase != LAST_PHASE) begin
                phase <= phase + 1'b1;
            end else begin
                phase <= '0;
                case (state)
                    SETUP: begin
                        sclk  <= 1'b1;
                        state <= HIGH;
                    end
                    HIGH: begin
                        sclk <= 1'b0;
                        rx   <= {rx[width-2:0], miso};
                        bits <= bits + 1'b1;
                        if (bits == LAST_BIT) begin
                            state <= HOLD;
                        end else begin
                            // Rotate so the next bit sits at the MSB; mosi moves with the falling edge.
                            tx    <= {tx[width-2:0], tx[width-1]};
                            mosi  <= tx[width-2];
                            state <= LOW;
                        end
                    end
                    LOW: begin
                        sclk  <= 1'b1;
                        state <= HIGH;
                    end
                    HOLD: begin
                        cs     <= 1'b1;
                        done   <= 1'b1;
                        rxdata <= rx;
                        state  <= GAP;
                    end
                    GAP: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_initiator.sv
// Directed bench for spi_initiator: peripheral model drives miso MSB first, monitor records edges and timing.
module tb_spi_initiator;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] txdata;
    logic       miso;
    logic       busy;
    logic       done;
    logic [7:0] rxdata;
    logic       cs;
    logic       sclk;
    logic       mosi;

    int errors = 0;
    int checks = 0;

    int         rises, falls, cs_f, cs_r, done_cnt, done_cyc;
    int         busy_first, busy_last, cs_fall_first, cs_fall_last, cs_rise_first;
    logic [7:0] mosi_word, rx_done;
    logic       cs_at_abort, sclk_at_abort;

    always #5 clk = ~clk;

    spi_initiator #(
        .width(8),
        .halfperiod(5),
        .counterwidth(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .txdata(txdata),
        .miso(miso),
        .busy(busy),
        .done(done),
        .rxdata(rxdata),
        .cs(cs),
        .sclk(sclk),
        .mosi(mosi)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Label k is the interval after edge k-1; inputs set at label k are seen by edge k.
    task automatic run_xfer(input logic [7:0] tx, input logic [7:0] pat, input int n,
                            input int hold_until, input int pulse_at, input int rst_at,
                            input int chg_at, input logic [7:0] chg_val);
        int   idx;
        logic pcs, psclk;
        rises = 0; falls = 0; cs_f = 0; cs_r = 0; done_cnt = 0; done_cyc = -1;
        busy_first = -1; busy_last = -1; cs_fall_first = -1; cs_fall_last = -1; cs_rise_first = -1;
        mosi_word = '0; rx_done = '0; cs_at_abort = 1'b0; sclk_at_abort = 1'b1;
        idx = 7;
        miso = pat[7];
        pcs = cs;
        psclk = sclk;
        txdata = tx;
        start = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (sclk && !psclk) begin
                rises++;
                mosi_word = {mosi_word[6:0], mosi};
            end
            if (!sclk && psclk) begin
                falls++;
                if (idx > 0) idx--;
            end
            if (!cs && pcs) begin
                cs_f++;
                if (cs_fall_first < 0) cs_fall_first = k;
                cs_fall_last = k;
                idx = 7;
            end
            if (cs && !pcs) begin
                cs_r++;
                if (cs_rise_first < 0) cs_rise_first = k;
            end
            miso = pat[idx];
            if (busy) begin
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
            if (done) begin
                done_cnt++;
                done_cyc = k;
                rx_done = rxdata;
            end
            if (k == rst_at + 1) begin
                cs_at_abort = cs;
                sclk_at_abort = sclk;
            end
            pcs = cs;
            psclk = sclk;
            start = (k < hold_until) || (k == pulse_at);
            reset = (k == rst_at);
            if (k == chg_at) txdata = chg_val;
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        txdata = '0;
        miso = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rxdata", rxdata, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic transfer
        run_xfer(8'hA5, 8'h3C, 100, 0, 0, 0, 0, 8'h00);
        check("basic_rises", rises, 8);
        check("basic_falls", falls, 8);
        check("basic_mosi", mosi_word, 8'hA5);
        check("basic_done_cyc", done_cyc, 86);
        check("basic_done_cnt", done_cnt, 1);
        check("basic_rx_done", rx_done, 8'h3C);
        check("basic_busy_first", busy_first, 1);
        check("basic_busy_last", busy_last, 90);
        check("basic_cs_fall", cs_fall_first, 1);
        check("basic_cs_rise", cs_rise_first, 86);
        check("basic_cs_edges", cs_f * 16 + cs_r, 17);
        check("basic_rx_hold", rxdata, 8'h3C);

        // start pulse while busy is ignored
        run_xfer(8'h5A, 8'h81, 120, 0, 30, 0, 0, 8'h00);
        check("pulse_done_cnt", done_cnt, 1);
        check("pulse_busy_last", busy_last, 90);
        check("pulse_mosi", mosi_word, 8'h5A);
        check("pulse_rx", rx_done, 8'h81);

        // start held high: back-to-back transfers
        run_xfer(8'h33, 8'hC6, 200, 92, 0, 0, 0, 8'h00);
        check("hold_done_cnt", done_cnt, 2);
        check("hold_cs_fall1", cs_fall_first, 1);
        check("hold_cs_rise1", cs_rise_first, 86);
        check("hold_cs_fall2", cs_fall_last, 92);
        check("hold_cs_falls", cs_f, 2);
        check("hold_rises", rises, 16);
        check("hold_rx", rx_done, 8'hC6);

        // txdata change after acceptance
        run_xfer(8'h0F, 8'h66, 100, 0, 0, 0, 10, 8'hF0);
        check("stab_mosi", mosi_word, 8'h0F);
        check("stab_rx", rxdata, 8'h66);

        // reset abort mid-transfer
        run_xfer(8'hFF, 8'h55, 100, 0, 0, 40, 0, 8'h00);
        check("abort_cs", cs_at_abort, 1);
        check("abort_sclk", sclk_at_abort, 0);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_rxdata", rxdata, 8'h66);
        check("abort_busy", busy, 0);

        // new transfer after abort
        run_xfer(8'hC3, 8'h99, 100, 0, 0, 0, 0, 8'h00);
        check("post_done_cyc", done_cyc, 86);
        check("post_rx", rx_done, 8'h99);
        check("post_mosi", mosi_word, 8'hC3);

        // idle reset clears rxdata
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("idle_rst_rxdata", rxdata, 0);
        check("idle_rst_cs", cs, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
